// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle, 32 steps.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] d_a,
  input  logic [31:0] d_b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic        is_div;
  logic        sa;
  logic        sb;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] a_raw;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [4:0]  cnt;

  logic        in_sa;
  logic        in_sb;
  logic [31:0] in_ma;
  logic [31:0] in_mb;

  // md_op[0]=1 selects the unsigned forms, which ignore operand signs
  assign in_sa = ~md_op[0] & d_a[31];
  assign in_sb = ~md_op[0] & d_b[31];
  assign in_ma = in_sa ? (32'd0 - d_a) : d_a;
  assign in_mb = in_sb ? (32'd0 - d_b) : d_b;

  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;

  assign mul_sum  = {1'b0, acc_hi}
                  + (acc_lo[0] ? {1'b0, mag_a} : 33'd0);
  assign div_sh   = {acc_hi, acc_lo[31]};
  assign div_ge   = div_sh >= {1'b0, mag_b};
  assign div_diff = div_sh[31:0] - mag_b;

  logic [63:0] prod;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = (sa ^ sb) ? (64'd0 - prod) : prod;
  assign quo_s  = (sa ^ sb) ? (32'd0 - acc_lo) : acc_lo;
  assign rem_s  = sa ? (32'd0 - acc_hi) : acc_hi;

  always_comb begin
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    if (is_div) begin
      if (mag_b == 32'd0) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      a_raw  <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hi_wr) hi <= wr_data;
          if (lo_wr) lo <= wr_data;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= 5'd0;
            is_div <= md_op[1];
            sa     <= in_sa;
            sb     <= in_sb;
            mag_a  <= in_ma;
            mag_b  <= in_mb;
            a_raw  <= d_a;
            acc_hi <= 32'd0;
            acc_lo <= md_op[1] ? in_ma : in_mb;
          end
        end
        CALC: begin
          if (is_div) begin
            acc_hi <= div_ge ? div_diff : div_sh[31:0];
            acc_lo <= {acc_lo[30:0], div_ge};
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
